// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // RV32 load/store funct3 encodings (loads and stores share 000/001/010)
    localparam logic [2:0] FN3_LB  = 3'b000;
    localparam logic [2:0] FN3_LH  = 3'b001;
    localparam logic [2:0] FN3_LW  = 3'b010;
    localparam logic [2:0] FN3_LBU = 3'b100;
    localparam logic [2:0] FN3_LHU = 3'b101;
    localparam logic [2:0] FN3_SB  = 3'b000;
    localparam logic [2:0] FN3_SH  = 3'b001;
    localparam logic [2:0] FN3_SW  = 3'b010;

    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for RV32 loads/stores plus alignment/encoding checks.
module lsu_lane_align
    import mem_arb_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out,
    output logic        misaligned
);

    logic [7:0]  rbyte [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbyte[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign sel_byte = rbyte[addr_lo];
    assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Unsigned variants and undefined encodings have no store form, so they flag as errors
    always_comb begin
        be         = 4'b0000;
        wdata_out  = 32'h0;
        rdata_out  = 32'h0;
        misaligned = 1'b0;
        case (fn3)
            FN3_LB: begin
                be        = 4'b0001 << addr_lo;
                wdata_out = {4{wdata[7:0]}};
                rdata_out = {{24{sel_byte[7]}}, sel_byte};
            end
            FN3_LH: begin
                misaligned = addr_lo[0];
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_out  = {2{wdata[15:0]}};
                rdata_out  = {{16{sel_half[15]}}, sel_half};
            end
            FN3_LW: begin
                misaligned = (addr_lo != 2'b00);
                be         = 4'b1111;
                wdata_out  = wdata;
                rdata_out  = rdata;
            end
            FN3_LBU: begin
                misaligned = we;
                rdata_out  = {24'h0, sel_byte};
            end
            FN3_LHU: begin
                misaligned = we | addr_lo[0];
                rdata_out  = {16'h0, sel_half};
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch and data load/store,
// sequencing each access as IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'h8000_0000,
    parameter int          MEM_AW        = 14,
    parameter int          MEM_LATENCY   = 1,
    parameter int          DATA_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [31:0]       d_req_addr,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_fn3,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    localparam int WAIT_CYCLES = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;

    state_t      state_reg, state_next;
    logic [2:0]  lat_cnt_reg, lat_cnt_next;
    owner_t      owner_reg, rr_reg;
    logic [31:0] req_addr_reg, req_wdata_reg;
    logic        req_we_reg;
    logic [2:0]  req_fn3_reg;

    logic        if_rsp_valid_reg, d_rsp_valid_reg, d_rsp_err_reg;
    logic [31:0] if_rsp_data_reg, d_rsp_data_reg;

    logic        grant_d, grant_if, contested, is_store;
    logic [29:0] word_idx;
    logic        out_of_range, req_err;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata;
    logic        lane_misaligned;

    assign contested    = if_req_valid & d_req_valid;
    assign grant_d      = d_req_valid & (~if_req_valid | (DATA_PRIORITY != 0) | (rr_reg == OWN_D));
    assign grant_if     = if_req_valid & ~grant_d;
    assign d_req_ready  = (state_reg == IDLE) & grant_d;
    assign if_req_ready = (state_reg == IDLE) & grant_if;
    assign busy         = (state_reg != IDLE);

    // Word index relative to BASE_ADDR; anything wrapping below base or past the RAM is rejected
    assign word_idx     = req_addr_reg[31:2] - BASE_ADDR[31:2];
    assign out_of_range = (req_addr_reg < BASE_ADDR) | (|word_idx[29:MEM_AW]);
    assign is_store     = (owner_reg == OWN_D) & req_we_reg;
    assign req_err      = out_of_range |
                          ((owner_reg == OWN_D) ? lane_misaligned : (req_addr_reg[1:0] != 2'b00));

    lsu_lane_align u_align (
        .we         (req_we_reg),
        .fn3        (req_fn3_reg),
        .addr_lo    (req_addr_reg[1:0]),
        .wdata      (req_wdata_reg),
        .rdata      (mem_rdata),
        .be         (lane_be),
        .wdata_out  (lane_wdata),
        .rdata_out  (lane_rdata),
        .misaligned (lane_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 3'd0;
        end else begin
            state_reg   <= state_next;
            lat_cnt_reg <= lat_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        lat_cnt_next = lat_cnt_reg;
        mem_en       = 1'b0;
        mem_be       = 4'b0000;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        case (state_reg)
            IDLE: begin
                if (if_req_ready | d_req_ready)
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (!req_err) begin
                    mem_en   = 1'b1;
                    mem_addr = word_idx[MEM_AW-1:0];
                    if (is_store) begin
                        mem_be    = lane_be;
                        mem_wdata = lane_wdata;
                    end
                end
                // Stores complete on the write strobe; they need no read-data wait
                if (req_err)
                    state_next = RESP;
                else if (is_store)
                    state_next = IDLE;
                else if (MEM_LATENCY > 1) begin
                    state_next   = WAIT;
                    lat_cnt_next = 3'(WAIT_CYCLES);
                end else
                    state_next = RESP;
            end
            WAIT: begin
                if (lat_cnt_reg == 3'd0)
                    state_next = RESP;
                else
                    lat_cnt_next = lat_cnt_reg - 3'd1;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg     <= OWN_IF;
            rr_reg        <= OWN_D;
            req_addr_reg  <= 32'h0;
            req_wdata_reg <= 32'h0;
            req_we_reg    <= 1'b0;
            req_fn3_reg   <= 3'b000;
        end else if (state_reg == IDLE) begin
            if (d_req_ready) begin
                owner_reg     <= OWN_D;
                req_addr_reg  <= d_req_addr;
                req_wdata_reg <= d_req_wdata;
                req_we_reg    <= d_req_we;
                req_fn3_reg   <= d_req_fn3;
            end else if (if_req_ready) begin
                owner_reg     <= OWN_IF;
                req_addr_reg  <= if_req_addr;
                req_wdata_reg <= 32'h0;
                req_we_reg    <= 1'b0;
                req_fn3_reg   <= FN3_LW;
            end
            if (contested && (DATA_PRIORITY == 0))
                rr_reg <= grant_d ? OWN_IF : OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rsp_valid_reg <= 1'b0;
            if_rsp_data_reg  <= 32'h0;
            d_rsp_valid_reg  <= 1'b0;
            d_rsp_data_reg   <= 32'h0;
            d_rsp_err_reg    <= 1'b0;
        end else begin
            if_rsp_valid_reg <= 1'b0;
            d_rsp_valid_reg  <= 1'b0;
            if (state_reg == ISSUE && is_store && !req_err) begin
                d_rsp_valid_reg <= 1'b1;
                d_rsp_data_reg  <= 32'h0;
                d_rsp_err_reg   <= 1'b0;
            end
            if (state_reg == RESP) begin
                if (owner_reg == OWN_IF) begin
                    if_rsp_valid_reg <= 1'b1;
                    if_rsp_data_reg  <= req_err ? NOP_INSN : mem_rdata;
                end else begin
                    d_rsp_valid_reg <= 1'b1;
                    d_rsp_err_reg   <= req_err;
                    d_rsp_data_reg  <= (req_err || req_we_reg) ? 32'h0 : lane_rdata;
                end
            end
        end
    end

    assign if_rsp_valid = if_rsp_valid_reg;
    assign if_rsp_data  = if_rsp_data_reg;
    assign d_rsp_valid  = d_rsp_valid_reg;
    assign d_rsp_data   = d_rsp_data_reg;
    assign d_rsp_err    = d_rsp_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: instance 0 = latency 1 / round-robin, instance 1 = latency 3 / data priority.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n        [2];
    logic          if_req_valid [2];
    logic          if_req_ready [2];
    logic [31:0]   if_req_addr  [2];
    logic          if_rsp_valid [2];
    logic [31:0]   if_rsp_data  [2];
    logic          d_req_valid  [2];
    logic          d_req_ready  [2];
    logic [31:0]   d_req_addr   [2];
    logic          d_req_we     [2];
    logic [2:0]    d_req_fn3    [2];
    logic [31:0]   d_req_wdata  [2];
    logic          d_rsp_valid  [2];
    logic [31:0]   d_rsp_data   [2];
    logic          d_rsp_err    [2];
    logic          mem_en       [2];
    logic [3:0]    mem_be       [2];
    logic [AW-1:0] mem_addr     [2];
    logic [31:0]   mem_wdata    [2];
    logic [31:0]   mem_rdata    [2];
    logic          busy         [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            mem_port_arbiter #(
                .BASE_ADDR     (32'h8000_0000),
                .MEM_AW        (AW),
                .MEM_LATENCY   ((gi == 0) ? 1 : 3),
                .DATA_PRIORITY ((gi == 0) ? 0 : 1)
            ) u_dut (
                .clk          (clk),
                .rst_n        (rst_n[gi]),
                .if_req_valid (if_req_valid[gi]),
                .if_req_ready (if_req_ready[gi]),
                .if_req_addr  (if_req_addr[gi]),
                .if_rsp_valid (if_rsp_valid[gi]),
                .if_rsp_data  (if_rsp_data[gi]),
                .d_req_valid  (d_req_valid[gi]),
                .d_req_ready  (d_req_ready[gi]),
                .d_req_addr   (d_req_addr[gi]),
                .d_req_we     (d_req_we[gi]),
                .d_req_fn3    (d_req_fn3[gi]),
                .d_req_wdata  (d_req_wdata[gi]),
                .d_rsp_valid  (d_rsp_valid[gi]),
                .d_rsp_data   (d_rsp_data[gi]),
                .d_rsp_err    (d_rsp_err[gi]),
                .mem_en       (mem_en[gi]),
                .mem_be       (mem_be[gi]),
                .mem_addr     (mem_addr[gi]),
                .mem_wdata    (mem_wdata[gi]),
                .mem_rdata    (mem_rdata[gi]),
                .busy         (busy[gi])
            );
        end
    endgenerate

    // RAM models: instance 0 returns data one cycle after the strobe, instance 1 three cycles
    logic [31:0] ram0 [2**AW];
    logic [31:0] ram1 [2**AW];
    logic [31:0] pipe0, p1a, p1b, p1c;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (mem_en[0] && mem_be[0] != 4'b0000)
            ram0[mem_addr[0]] <= merge(ram0[mem_addr[0]], mem_wdata[0], mem_be[0]);
        pipe0 <= ram0[mem_addr[0]];
        if (mem_en[1] && mem_be[1] != 4'b0000)
            ram1[mem_addr[1]] <= merge(ram1[mem_addr[1]], mem_wdata[1], mem_be[1]);
        p1a <= ram1[mem_addr[1]];
        p1b <= p1a;
        p1c <= p1b;
    end
    assign mem_rdata[0] = pipe0;
    assign mem_rdata[1] = p1c;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t qi0[$], qd0[$], qi1[$], qd1[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        tests++;
        fails++;
        $display("FAIL %s: response pulse with no expected entry (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops one expectation per response pulse, independent of the stimulus thread
    always @(negedge clk) begin
        exp_t e;
        if (if_rsp_valid[0]) begin
            if (qi0.size() == 0) unexpected("if0_rsp");
            else begin
                e = qi0.pop_front();
                chk("if0_data", if_rsp_data[0], e.data);
                chk("if0_cycle", cyc, e.cyc);
                $display("[TB] if0 rsp data=%h cycle=%0d", if_rsp_data[0], cyc);
            end
        end
        if (d_rsp_valid[0]) begin
            if (qd0.size() == 0) unexpected("d0_rsp");
            else begin
                e = qd0.pop_front();
                chk("d0_data", d_rsp_data[0], e.data);
                chk("d0_err", d_rsp_err[0], e.err);
                chk("d0_cycle", cyc, e.cyc);
                $display("[TB] d0 rsp data=%h err=%0b cycle=%0d", d_rsp_data[0], d_rsp_err[0], cyc);
            end
        end
        if (if_rsp_valid[1]) begin
            if (qi1.size() == 0) unexpected("if1_rsp");
            else begin
                e = qi1.pop_front();
                chk("if1_data", if_rsp_data[1], e.data);
                chk("if1_cycle", cyc, e.cyc);
                $display("[TB] if1 rsp data=%h cycle=%0d", if_rsp_data[1], cyc);
            end
        end
        if (d_rsp_valid[1]) begin
            if (qd1.size() == 0) unexpected("d1_rsp");
            else begin
                e = qd1.pop_front();
                chk("d1_data", d_rsp_data[1], e.data);
                chk("d1_err", d_rsp_err[1], e.err);
                chk("d1_cycle", cyc, e.cyc);
                $display("[TB] d1 rsp data=%h err=%0b cycle=%0d", d_rsp_data[1], d_rsp_err[1], cyc);
            end
        end
    end

    task automatic push_d(input int inst, input logic [31:0] data, input logic err, input int c);
        exp_t e;
        e.data = data; e.err = err; e.cyc = c;
        if (inst == 0) qd0.push_back(e); else qd1.push_back(e);
    endtask

    task automatic push_if(input int inst, input logic [31:0] data, input int c);
        exp_t e;
        e.data = data; e.err = 1'b0; e.cyc = c;
        if (inst == 0) qi0.push_back(e); else qi1.push_back(e);
    endtask

    // Returns #1 after the handshake edge, i.e. inside the ISSUE cycle
    task automatic issue_d(input int inst, input logic we, input logic [2:0] fn3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_data, input logic exp_err,
                           input int lat, input bit push);
        bit ok = 0;
        @(negedge clk);
        d_req_valid[inst] = 1'b1;
        d_req_we[inst]    = we;
        d_req_fn3[inst]   = fn3;
        d_req_addr[inst]  = addr;
        d_req_wdata[inst] = wdata;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (d_req_ready[inst]) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL d%0d_handshake: ready never seen, expected within 50 cycles", inst);
        end else if (push)
            push_d(inst, exp_data, exp_err, cyc + lat);
        @(posedge clk);
        #1;
        d_req_valid[inst] = 1'b0;
    endtask

    task automatic issue_if(input int inst, input logic [31:0] addr,
                            input logic [31:0] exp_data, input int lat);
        bit ok = 0;
        @(negedge clk);
        if_req_valid[inst] = 1'b1;
        if_req_addr[inst]  = addr;
        for (int t = 0; t < 50; t++) begin
            #1;
            if (if_req_ready[inst]) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL if%0d_handshake: ready never seen, expected within 50 cycles", inst);
        end else
            push_if(inst, exp_data, cyc + lat);
        @(posedge clk);
        #1;
        if_req_valid[inst] = 1'b0;
    endtask

    task automatic drain();
        int left;
        for (int i = 0; i < 40; i++) begin
            if (qi0.size() + qd0.size() + qi1.size() + qd1.size() == 0) break;
            @(negedge clk);
        end
        left = qi0.size() + qd0.size() + qi1.size() + qd1.size();
        if (left != 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", left);
            qi0.delete(); qd0.delete(); qi1.delete(); qd1.delete();
        end
        @(negedge clk);
    endtask

    task automatic ld(input int inst, input logic [2:0] fn3, input logic [31:0] addr,
                      input logic [31:0] exp_data, input logic exp_err, input int lat);
        issue_d(inst, 1'b0, fn3, addr, 32'h0, exp_data, exp_err, exp_err ? 3 : lat, 1);
        chk("ld_mem_en", mem_en[inst], !exp_err);
        chk("ld_mem_be", mem_be[inst], 4'b0000);
        drain();
    endtask

    task automatic st(input int inst, input logic [2:0] fn3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] exp_be,
                      input logic [31:0] exp_wdata, input logic [AW-1:0] exp_maddr,
                      input logic exp_err);
        issue_d(inst, 1'b1, fn3, addr, wdata, 32'h0, exp_err, exp_err ? 3 : 2, 1);
        if (exp_err)
            chk("st_no_mem_en", mem_en[inst], 1'b0);
        else begin
            chk("st_mem_en", mem_en[inst], 1'b1);
            chk("st_mem_be", mem_be[inst], exp_be);
            chk("st_mem_wdata", mem_wdata[inst], exp_wdata);
            chk("st_mem_addr", mem_addr[inst], exp_maddr);
        end
        drain();
    endtask

    task automatic fetch(input int inst, input logic [31:0] addr, input logic [31:0] exp_data,
                         input int lat);
        issue_if(inst, addr, exp_data, lat);
        drain();
    endtask

    // Both requesters held valid; records which side wins each of n grants (bit k = 1 for data)
    task automatic arb(input int inst, input int n, input logic [3:0] exp_pat,
                       input logic [31:0] word, input int lat);
        logic [3:0] pat = 4'b0000;
        int k = 0;
        @(negedge clk);
        if_req_valid[inst] = 1'b1;
        if_req_addr[inst]  = 32'h8000_0004;
        d_req_valid[inst]  = 1'b1;
        d_req_addr[inst]   = 32'h8000_0004;
        d_req_we[inst]     = 1'b0;
        d_req_fn3[inst]    = FN3_LW;
        d_req_wdata[inst]  = 32'h0;
        for (int t = 0; t < 80 && k < n; t++) begin
            #1;
            if (d_req_ready[inst] || if_req_ready[inst]) begin
                chk("arb_one_grant", if_req_ready[inst] & d_req_ready[inst], 1'b0);
                pat[k] = d_req_ready[inst];
                if (d_req_ready[inst]) push_d(inst, word, 1'b0, cyc + lat);
                else                   push_if(inst, word, cyc + lat);
                k++;
            end
            @(posedge clk);
            if (k < n) @(negedge clk);
        end
        #1;
        if_req_valid[inst] = 1'b0;
        d_req_valid[inst]  = 1'b0;
        chk("arb_grant_count", k, n);
        chk("arb_pattern", pat, exp_pat);
        $display("[TB] arb inst%0d grant pattern=%b", inst, pat);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ram0[i] = 32'h0;
            ram1[i] = 32'h0;
        end
        ram0[1]        = 32'h0050_0093;
        ram0[2**AW-1]  = 32'hCAFE_F00D;
        ram1[1]        = 32'h8001_1234;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            if_req_valid[i] = 1'b0; if_req_addr[i] = 32'h0;
            d_req_valid[i] = 1'b0;  d_req_addr[i] = 32'h0;
            d_req_we[i] = 1'b0;     d_req_fn3[i] = 3'b000; d_req_wdata[i] = 32'h0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            chk("reset_outputs",
                {if_req_ready[i], if_rsp_valid[i], if_rsp_data[i], d_req_ready[i], d_rsp_valid[i],
                 d_rsp_data[i], d_rsp_err[i], mem_en[i], mem_be[i], mem_addr[i], mem_wdata[i], busy[i]},
                128'h0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);

        // Fetch and byte/halfword/word store-load round trips on the latency-1 instance
        fetch(0, 32'h8000_0004, 32'h0050_0093, 3);
        st(0, FN3_SB, 32'h8000_0103, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 14'h040, 1'b0);
        ld(0, FN3_LB,  32'h8000_0103, 32'hFFFF_FFAB, 1'b0, 3);
        ld(0, FN3_LBU, 32'h8000_0103, 32'h0000_00AB, 1'b0, 3);
        st(0, FN3_SH, 32'h8000_0202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 14'h080, 1'b0);
        ld(0, FN3_LW,  32'h8000_0200, 32'hBEEF_0000, 1'b0, 3);
        ld(0, FN3_LH,  32'h8000_0202, 32'hFFFF_BEEF, 1'b0, 3);
        ld(0, FN3_LHU, 32'h8000_0202, 32'h0000_BEEF, 1'b0, 3);
        st(0, FN3_SW, 32'h8000_0300, 32'h1234_5678, 4'b1111, 32'h1234_5678, 14'h0C0, 1'b0);
        ld(0, FN3_LB,  32'h8000_0301, 32'h0000_0056, 1'b0, 3);
        ld(0, FN3_LH,  32'h8000_0300, 32'h0000_5678, 1'b0, 3);

        // Error paths and range boundaries
        ld(0, FN3_LW,  32'h8000_0002, 32'h0, 1'b1, 3);
        ld(0, FN3_LW,  32'h7FFF_FFFC, 32'h0, 1'b1, 3);
        ld(0, FN3_LW,  32'h8001_0000, 32'h0, 1'b1, 3);
        ld(0, FN3_LW,  32'h8000_FFFC, 32'hCAFE_F00D, 1'b0, 3);
        ld(0, 3'b011,  32'h8000_0000, 32'h0, 1'b1, 3);
        st(0, FN3_SH,  32'h8000_0001, 32'h0000_1111, 4'b0000, 32'h0, 14'h0, 1'b1);
        st(0, FN3_LBU, 32'h8000_0000, 32'h0000_0022, 4'b0000, 32'h0, 14'h0, 1'b1);
        fetch(0, 32'h8000_0006, NOP_INSN, 3);
        fetch(0, 32'h0000_0000, NOP_INSN, 3);
        ld(1, FN3_LW,  32'h8000_0002, 32'h0, 1'b1, 3);

        // Arbitration: round-robin alternates starting with data; data priority starves fetch
        arb(0, 4, 4'b0101, 32'h0050_0093, 3);
        arb(1, 4, 4'b1111, 32'h8001_1234, 5);
        fetch(1, 32'h8000_0004, 32'h8001_1234, 5);

        // Reset during WAIT drops the access; next request completes normally
        issue_d(1, 1'b0, FN3_LW, 32'h8000_0004, 32'h0, 32'h0, 1'b0, 5, 0);
        @(posedge clk);
        #1;
        chk("busy_in_wait", busy[1], 1'b1);
        rst_n[1] = 1'b0;
        #1;
        chk("busy_after_rst", busy[1], 1'b0);
        chk("no_rsp_after_rst", d_rsp_valid[1], 1'b0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (8) @(negedge clk);
        ld(1, FN3_LH, 32'h8000_0006, 32'hFFFF_8001, 1'b0, 5);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
